// File: rtl/isqrt_arb.sv
// isqrt_arb: three-requester front end for one shared pipelined integer square root.
// It arbitrates the requests, issues the operands to the isqrt through registers, and
// tracks each operand through a tag pipe so results return one-hot to the right requester.
// Optional feature macro: ISQRT_ARB_FIXED_PRIO_EN. When it is defined, arbitration is fixed
// priority 0>1>2. When it is undefined (the default), arbitration is round-robin.
module isqrt_arb #(
    parameter int ISQRT_LAT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_vld,
    input  logic [31:0] req_x0,
    input  logic [31:0] req_x1,
    input  logic [31:0] req_x2,
    output logic [2:0]  req_rdy,
    output logic        iq_x_vld,
    output logic [31:0] iq_x,
    input  logic        iq_y_vld,
    input  logic [15:0] iq_y,
    output logic [2:0]  rsp_vld,
    output logic [15:0] rsp_y,
    output logic        busy,
    output logic        err
);

    logic [2:0]           grant;
    logic [1:0]           gnt_id;
    logic [31:0]          sel_x;
    logic                 xfer;
    logic [1:0]           iq_id;
    logic [ISQRT_LAT-1:0] tag_vld;
    logic [1:0]           tail_id;
    logic                 tail_vld;
    logic [2:0]           rsp_hot;

`ifdef ISQRT_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-numbered valid requester wins.
    always_comb begin
        grant = 3'b000;
        if (req_vld[0])      grant = 3'b001;
        else if (req_vld[1]) grant = 3'b010;
        else if (req_vld[2]) grant = 3'b100;
    end
`else
    logic [1:0] ptr;

    // Round-robin: the search starts at the requester after the last granted one.
    always_comb begin
        grant = 3'b000;
        case (ptr)
            2'd0: begin
                if (req_vld[1])      grant = 3'b010;
                else if (req_vld[2]) grant = 3'b100;
                else if (req_vld[0]) grant = 3'b001;
            end
            2'd1: begin
                if (req_vld[2])      grant = 3'b100;
                else if (req_vld[0]) grant = 3'b001;
                else if (req_vld[1]) grant = 3'b010;
            end
            default: begin
                if (req_vld[0])      grant = 3'b001;
                else if (req_vld[1]) grant = 3'b010;
                else if (req_vld[2]) grant = 3'b100;
            end
        endcase
    end

    // The pointer moves only on an actual transfer. It resets to 2 so that the first search starts at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      ptr <= 2'd2;
        else if (xfer) ptr <= gnt_id;
    end
`endif

    // Grants are masked while reset is held, so nothing is accepted before the first live edge.
    assign req_rdy = rst ? grant : 3'b000;
    assign xfer    = |req_rdy;

    // Encode the winner and select its operand. The operand is taken live because it need not be stable before the grant.
    always_comb begin
        gnt_id = 2'd0;
        sel_x  = req_x0;
        if (grant[1]) begin
            gnt_id = 2'd1;
            sel_x  = req_x1;
        end
        if (grant[2]) begin
            gnt_id = 2'd2;
            sel_x  = req_x2;
        end
    end

    // Issue register. iq_x and iq_id hold between transfers so the isqrt input does not toggle when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iq_x_vld <= 1'b0;
            iq_x     <= 32'd0;
            iq_id    <= 2'd0;
        end else begin
            iq_x_vld <= xfer;
            if (xfer) begin
                iq_x  <= sel_x;
                iq_id <= gnt_id;
            end
        end
    end

    // The tag pipe follows iq_x_vld through the isqrt. Its tail lines up with iq_y_vld.
    for (genvar gi = 0; gi < ISQRT_LAT; gi++) begin : g_tag
        logic       vld_q;
        logic [1:0] id_q;
        logic       vld_in;
        logic [1:0] id_in;

        if (gi == 0) begin : g_head
            assign vld_in = iq_x_vld;
            assign id_in  = iq_id;
        end else begin : g_body
            assign vld_in = g_tag[gi-1].vld_q;
            assign id_in  = g_tag[gi-1].id_q;
        end

        // One tag stage advances every cycle and is cleared by reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= 1'b0;
                id_q  <= 2'd0;
            end else begin
                vld_q <= vld_in;
                id_q  <= id_in;
            end
        end

        assign tag_vld[gi] = vld_q;
    end

    assign tail_vld = g_tag[ISQRT_LAT-1].vld_q;
    assign tail_id  = g_tag[ISQRT_LAT-1].id_q;

    // Route a matched result one-hot to the requester named by the tail tag.
    always_comb begin
        rsp_hot = 3'b000;
        if (iq_y_vld && tail_vld) begin
            case (tail_id)
                2'd0:    rsp_hot = 3'b001;
                2'd1:    rsp_hot = 3'b010;
                default: rsp_hot = 3'b100;
            endcase
        end
    end

    // Response register. A result without a tag, or a tag without a result, is dropped and recorded in err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld <= 3'b000;
            rsp_y   <= 16'd0;
            err     <= 1'b0;
        end else begin
            rsp_vld <= rsp_hot;
            if (|rsp_hot) rsp_y <= iq_y;
            if (iq_y_vld != tail_vld) err <= 1'b1;
        end
    end

    assign busy = iq_x_vld | (|tag_vld) | (|rsp_vld);

endmodule

// File: tb/tb_isqrt_arb.sv
// tb_isqrt_arb: directed bench for isqrt_arb. It contains a behavioural pipelined isqrt
// and a scoreboard queue of expected responses, each with its expected arrival cycle.
module tb_isqrt_arb;

    localparam int LAT = 16;

    logic        clk;
    logic        rst;
    logic [2:0]  req_vld;
    logic [31:0] req_x0, req_x1, req_x2;
    logic [2:0]  req_rdy;
    logic        iq_x_vld;
    logic [31:0] iq_x;
    logic        iq_y_vld;
    logic [15:0] iq_y;
    logic [2:0]  rsp_vld;
    logic [15:0] rsp_y;
    logic        busy;
    logic        err;
    logic        force_y;

    isqrt_arb #(.ISQRT_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld),
        .req_x0(req_x0), .req_x1(req_x1), .req_x2(req_x2),
        .req_rdy(req_rdy), .iq_x_vld(iq_x_vld), .iq_x(iq_x),
        .iq_y_vld(iq_y_vld), .iq_y(iq_y),
        .rsp_vld(rsp_vld), .rsp_y(rsp_y), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        logic [63:0] sq;
        r = 16'd0;
        for (int b = 15; b >= 0; b--) begin
            t  = r | (16'd1 << b);
            sq = 64'(t) * 64'(t);
            if (sq <= 64'(x)) r = t;
        end
        return r;
    endfunction

    // Behavioural shared isqrt. y_vld follows x_vld by LAT cycles, and reset clears it with the DUT.
    logic        p_vld [LAT];
    logic [15:0] p_y   [LAT];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) p_vld[i] <= 1'b0;
        end else begin
            p_vld[0] <= iq_x_vld;
            p_y[0]   <= isqrt(iq_x);
            for (int i = 1; i < LAT; i++) begin
                p_vld[i] <= p_vld[i-1];
                p_y[i]   <= p_y[i-1];
            end
        end
    end
    assign iq_y_vld = p_vld[LAT-1] | force_y;
    assign iq_y     = p_y[LAT-1];

    typedef struct {
        logic [2:0]  hot;
        logic [15:0] y;
        int          due;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;
    int   cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample just after the negedge. Record transfers, pop and check responses, then advance one clock.
    task automatic cycle();
        logic [2:0]  xf;
        logic [31:0] x;
        exp_t        e;
        #1;
        xf = req_vld & req_rdy;
        if (xf != 3'b000) begin
            chk("grant_onehot", 32'($onehot(xf)), 32'd1);
            x = xf[0] ? req_x0 : (xf[1] ? req_x1 : req_x2);
            e.hot = xf;
            e.y   = isqrt(x);
            e.due = cyc + LAT + 2;
            q.push_back(e);
        end
        if (rsp_vld != 3'b000) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_vld), 32'd0);
            end else begin
                e = q.pop_front();
                $display("rsp cyc=%0d vld=%b y=%0d exp_vld=%b exp_y=%0d", cyc, rsp_vld, rsp_y, e.hot, e.y);
                chk("rsp_vld", 32'(rsp_vld), 32'(e.hot));
                chk("rsp_y", 32'(rsp_y), 32'(e.y));
                chk("rsp_latency", 32'(cyc), 32'(e.due));
                chk("busy_on_rsp", 32'(busy), 32'd1);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Run until every expected response has arrived, with a cycle budget as the bound.
    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    logic [2:0] exp_g [6];

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        force_y  = 1'b0;
        rst      = 1'b0;
        req_vld  = 3'b111;
        req_x0   = 32'd5;
        req_x1   = 32'd6;
        req_x2   = 32'd7;

        // Reset state. Requests are present but must stay masked.
        @(negedge clk);
        #1;
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_iq_x_vld", 32'(iq_x_vld), 32'd0);
        chk("rst_iq_x", iq_x, 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        req_vld = 3'b000;
        cycle();

        // All three requesters held valid for six cycles.
`ifdef ISQRT_ARB_FIXED_PRIO_EN
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
        req_x0 = 32'd1;
        req_x1 = 32'd4;
        req_x2 = 32'd9;
        for (int k = 0; k < 6; k++) begin
            req_vld = 3'b111;
            #1;
            $display("grant step=%0d req_rdy=%b exp=%b", k, req_rdy, exp_g[k]);
            chk("rr_grant", 32'(req_rdy), 32'(exp_g[k]));
            cycle();
        end
        req_vld = 3'b000;
        drain();

        // A single request from requester 1.
        req_vld = 3'b010;
        req_x1  = 32'd144;
        #1;
        chk("single_rdy", 32'(req_rdy), 32'b010);
        cycle();
        req_vld = 3'b000;
        req_x1  = 32'd77;
        #1;
        chk("single_iq_x_vld", 32'(iq_x_vld), 32'd1);
        chk("single_iq_x", iq_x, 32'd144);
        drain();
        #1;
        chk("busy_after_last_rsp", 32'(busy), 32'd0);
        chk("iq_x_hold", iq_x, 32'd144);

        // Boundary operands.
        req_vld = 3'b001;
        req_x0  = 32'd0;
        cycle();
        req_vld = 3'b100;
        req_x2  = 32'hFFFF_FFFF;
        cycle();
        req_vld = 3'b000;
        drain();
        #1;
        chk("busy_after_boundary", 32'(busy), 32'd0);

        // Sustained issue from requester 0. Responses overlap with new grants.
        for (int k = 0; k < LAT + 6; k++) begin
            req_vld = 3'b001;
            req_x0  = 32'(k * k + 3 * k);
            #1;
            chk("stream_rdy", 32'(req_rdy), 32'b001);
            cycle();
        end
        req_vld = 3'b000;
        drain();

        // Reset in the middle of four in-flight operations.
        req_x0 = 32'd16;
        req_x1 = 32'd25;
        req_x2 = 32'd36;
        for (int k = 0; k < 4; k++) begin
            req_vld = 3'b111;
            cycle();
        end
        req_vld = 3'b000;
        repeat (LAT / 2 - 4) cycle();
        rst = 1'b0;
        q.delete();
        cycle();
        rst = 1'b1;
        repeat (LAT + 4) cycle();
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        req_vld = 3'b001;
        req_x0  = 32'd49;
        cycle();
        req_vld = 3'b000;
        drain();

        // Orphan result while the pipe is empty.
        force_y = 1'b1;
        cycle();
        force_y = 1'b0;
        #1;
        chk("orphan_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("orphan_err", 32'(err), 32'd1);
        repeat (5) cycle();
        #1;
        chk("orphan_err_sticky", 32'(err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/isqrt_arb.md
ISQRT_ARB -- requirements
Module: isqrt_arb

Interface
REQ-001 Parameter ISQRT_LAT, default 16, cycles from isqrt x_vld to matching y_vld; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_vld  input  3  per-requester request valid; bit i = requester i.
REQ-005 req_x0, req_x1, req_x2  input  32 each  operands of requesters 0..2.
REQ-006 req_rdy  output  3  per-requester grant; one-hot or zero.
REQ-007 iq_x_vld  output  1  drives x_vld of the shared pipelined isqrt.
REQ-008 iq_x  output  32  drives x of the shared isqrt.
REQ-009 iq_y_vld  input  1  y_vld from the shared isqrt.
REQ-010 iq_y  input  16  y from the shared isqrt.
REQ-011 rsp_vld  output  3  one-hot response valid; bit i = result for requester i.
REQ-012 rsp_y  output  16  result data, shared by all requesters.
REQ-013 busy  output  1  high while any operation is in flight.
REQ-014 err  output  1  sticky protocol-mismatch flag.

Function
REQ-015 req_rdy SHALL be combinational from req_vld and the priority state; a transfer occurs on a cycle with req_vld[i] & req_rdy[i].
REQ-016 At most one req_rdy bit SHALL be high per cycle; req_rdy SHALL be zero when req_vld is zero.
REQ-017 Default arbitration SHALL be round-robin: search starts at the requester after the last granted one, wrapping 2->0; the pointer updates only on a transfer.
REQ-018 A transfer at cycle T SHALL produce iq_x_vld=1 and iq_x=req_xi at T+1 (registered); iq_x_vld=0 otherwise.
REQ-019 iq_x SHALL hold its value when no transfer occurs (no toggling on idle cycles, for power).
REQ-020 The block SHALL keep an ISQRT_LAT-deep tag shift register (valid + 2-bit id) advancing every cycle, aligned with iq_x_vld.
REQ-021 When iq_y_vld=1 and the tag at the pipe tail is valid, rsp_vld[id] SHALL be 1 and rsp_y=iq_y in the next cycle (registered); total latency from transfer to response = ISQRT_LAT+2 cycles.
REQ-022 rsp_y SHALL update only on a response cycle; rsp_vld=0 otherwise.
REQ-023 Throughput SHALL be one transfer per cycle sustained; responses return in transfer order.
REQ-024 A requester SHALL be able to receive a response and be granted a new request in the same cycle.
REQ-025 busy SHALL be 1 whenever iq_x_vld, any tag valid bit, or any rsp_vld bit is 1.
REQ-026 err SHALL set on iq_y_vld=1 with invalid tail tag, or valid tail tag with iq_y_vld=0; the orphan response is dropped and err stays 1 until reset.
REQ-027 Requests with req_vld held but not granted SHALL not be lost; the block SHALL not require req_x to be stable before grant.

Reset
REQ-028 On rst low, asynchronously: req_rdy is masked to 0, iq_x_vld=0, iq_x=0, all tags invalid, rsp_vld=0, rsp_y=0, busy=0, err=0, round-robin pointer=2 (next grant search starts at 0).
REQ-029 Operations in flight when reset asserts SHALL be discarded without response; the first grant after release SHALL occur no earlier than the first clk edge with rst high.

Configuration
REQ-030 Macro ISQRT_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority 0>1>2 and the round-robin pointer is not instantiated; when undefined, REQ-017 applies.

Verification
REQ-031 Single request: req_vld=3'b010, req_x1=144 at T -> req_rdy=3'b010 at T; iq_x_vld=1, iq_x=144 at T+1; rsp_vld=3'b010, rsp_y=12 at T+ISQRT_LAT+2.
REQ-032 All three held valid 6 cycles, x0=1, x1=4, x2=9 (macro undefined) -> grants 0,1,2,0,1,2; responses rsp_y 1,2,3,1,2,3 routed one-hot in the same order, back-to-back.
REQ-033 Same stimulus with ISQRT_ARB_FIXED_PRIO_EN defined -> requester 0 granted all 6 cycles; requesters 1,2 get no response.
REQ-034 Boundary values: x=0 -> rsp_y=0; x=32'hFFFF_FFFF -> rsp_y=16'hFFFF; busy falls to 0 exactly one cycle after the last rsp_vld.
REQ-035 Reset mid-flight: 4 transfers, rst low 1 cycle at ISQRT_LAT/2 -> no rsp_vld afterwards, busy=0, err=0; next request completes normally.
REQ-036 Forced iq_y_vld=1 with empty pipe -> rsp_vld stays 0, err=1 next cycle and remains 1 until reset.
